// File: rtl/power_sequencer_pkg.sv
// ============================================================================
// Module      : power_sequencer_pkg
// Description : Shared state encodings, component indices and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package power_sequencer_pkg;

    localparam int SWIDTH = 3;

    typedef enum logic [SWIDTH-1:0] {
        S_OFF   = 3'd0,
        S_RESET = 3'd1,
        S_STAGE = 3'd2,
        S_RUN   = 3'd3,
        S_SHED  = 3'd4
    } state_t;

    localparam logic [1:0] AIRFLOW   = 2'd0;
    localparam logic [1:0] THRUSTERS = 2'd1;
    localparam logic [1:0] SOLAR     = 2'd2;

    // (p + k) mod 3 for p, k in 0..2
    function automatic logic [1:0] rr_step(input logic [1:0] p, input logic [1:0] k);
        logic [2:0] sum;
        sum = {1'b0, p} + {1'b0, k};
        if (sum >= 3'd3) begin
            sum = sum - 3'd3;
        end
        return sum[1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/power_grant_arbiter.sv
// ============================================================================
// Module      : power_grant_arbiter
// Description : Combinational greedy budget arbiter with round-robin order.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module power_grant_arbiter
    import power_sequencer_pkg::*;
#(
    parameter int DEMAND_W = 8,
    parameter int BUDGET_W = 11
) (
    input  logic [2:0]          req_i,
    input  logic [DEMAND_W-1:0] demand0_i,
    input  logic [DEMAND_W-1:0] demand1_i,
    input  logic [DEMAND_W-1:0] demand2_i,
    input  logic [BUDGET_W-1:0] budget_i,
    input  logic [1:0]          rr_ptr_i,
    input  logic                alert_i,
    input  logic                shed_i,
    output logic [2:0]          grant_next_o,
    output logic [BUDGET_W-1:0] spent_o,
    output logic [1:0]          rr_ptr_next_o
);

    logic                w_air_first;
    logic [2:0]          w_req_eff;
    logic [BUDGET_W-1:0] w_remain;
    logic [BUDGET_W-1:0] w_dem;
    logic [1:0]          w_idx;
    logic                w_visit;

    assign w_air_first = alert_i | shed_i;
    assign w_req_eff   = req_i & {1'b1, ~shed_i, 1'b1};

    // Slot 0 is the airflow priority slot; slots 1..3 walk round-robin.
    always_comb begin
        grant_next_o  = '0;
        spent_o       = '0;
        rr_ptr_next_o = rr_ptr_i;
        w_remain      = budget_i;
        w_idx         = AIRFLOW;
        w_visit       = 1'b0;
        w_dem         = '0;
        for (int s = 0; s < 4; s++) begin
            if (s == 0) begin
                w_idx   = AIRFLOW;
                w_visit = w_air_first;
            end else begin
                w_idx   = rr_step(rr_ptr_i, 2'(s - 1));
                w_visit = !(w_air_first && (w_idx == AIRFLOW));
            end
            case (w_idx)
                AIRFLOW:   w_dem = BUDGET_W'(demand0_i);
                THRUSTERS: w_dem = BUDGET_W'(demand1_i);
                default:   w_dem = BUDGET_W'(demand2_i);
            endcase
            if (w_visit && w_req_eff[w_idx] && (w_dem <= w_remain)) begin
                grant_next_o[w_idx] = 1'b1;
                w_remain            = w_remain - w_dem;
                spent_o             = spent_o + w_dem;
                rr_ptr_next_o       = rr_step(w_idx, 2'd1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/power_sequencer.sv
// ============================================================================
// Module      : power_sequencer
// Description : Staged component start-up plus run-time power budgeting
//               with hysteretic thruster load shedding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module power_sequencer
    import power_sequencer_pkg::*;
#(
    parameter int DEMAND_W   = 8,
    parameter int BATT_W     = 10,
    parameter int BATT_CAP   = 1000,
    parameter int BATT_INIT  = 500,
    parameter int LOW_MARK   = 100,
    parameter int HIGH_MARK  = 300,
    parameter int RST_CYCLES = 4,
    parameter int STAGGER    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [2:0]          req_i,
    input  logic [DEMAND_W-1:0] demand0_i,
    input  logic [DEMAND_W-1:0] demand1_i,
    input  logic [DEMAND_W-1:0] demand2_i,
    input  logic [DEMAND_W-1:0] gen_i,
    input  logic                alert_i,
    output logic [2:0]          en_o,
    output logic [2:0]          comp_rst_o,
    output logic [2:0]          grant_o,
    output logic [BATT_W-1:0]   battery_o,
    output logic                brownout_o
);

    localparam int BUDGET_W = BATT_W + 1;
    localparam int CNT_MAX  = (3 * STAGGER > RST_CYCLES) ? 3 * STAGGER : RST_CYCLES;
    localparam int CNT_W    = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0]    C_RST_LAST   = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]    C_AIR_CNT    = CNT_W'(STAGGER - 1);
    localparam logic [CNT_W-1:0]    C_THR_CNT    = CNT_W'(2 * STAGGER - 1);
    localparam logic [CNT_W-1:0]    C_STAGE_LAST = CNT_W'(3 * STAGGER - 1);
    localparam logic [BUDGET_W-1:0] C_CAP_EXT    = BUDGET_W'(BATT_CAP);

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2:0]          en_q;
    logic [2:0]          comp_rst_q;
    logic [2:0]          grant_q;
    logic [BATT_W-1:0]   battery_q;
    logic                brownout_q;
    logic [1:0]          rr_ptr_q;

    logic                w_active;
    logic [2:0]          w_arb_req;
    logic [BUDGET_W-1:0] w_budget;
    logic [BUDGET_W-1:0] w_spent;
    logic [BUDGET_W-1:0] w_remain;
    logic [2:0]          grant_d;
    logic [1:0]          rr_ptr_d;
    logic [BATT_W-1:0]   battery_d;

    assign w_active  = (state_q == S_RUN) || (state_q == S_SHED);
    assign w_arb_req = w_active ? req_i : 3'b000;
    assign w_budget  = {1'b0, battery_q} + BUDGET_W'(gen_i);

    power_grant_arbiter #(
        .DEMAND_W (DEMAND_W),
        .BUDGET_W (BUDGET_W)
    ) u_arbiter (
        .req_i         (w_arb_req),
        .demand0_i     (demand0_i),
        .demand1_i     (demand1_i),
        .demand2_i     (demand2_i),
        .budget_i      (w_budget),
        .rr_ptr_i      (rr_ptr_q),
        .alert_i       (alert_i),
        .shed_i        (state_q == S_SHED),
        .grant_next_o  (grant_d),
        .spent_o       (w_spent),
        .rr_ptr_next_o (rr_ptr_d)
    );

    // The arbiter never spends more than the budget, so this cannot wrap.
    assign w_remain  = w_budget - w_spent;
    assign battery_d = (w_remain > C_CAP_EXT) ? BATT_W'(BATT_CAP) : w_remain[BATT_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_OFF;
            cnt_q      <= '0;
            en_q       <= 3'b000;
            comp_rst_q <= 3'b111;
            grant_q    <= 3'b000;
            battery_q  <= BATT_W'(BATT_INIT);
            brownout_q <= 1'b0;
            rr_ptr_q   <= 2'd0;
        end else if ((state_q != S_OFF) && !start_i) begin
            state_q    <= S_OFF;
            cnt_q      <= '0;
            en_q       <= 3'b000;
            comp_rst_q <= 3'b111;
            grant_q    <= 3'b000;
            brownout_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_OFF: begin
                    if (start_i) begin
                        state_q <= S_RESET;
                        cnt_q   <= '0;
                    end
                end
                S_RESET: begin
                    battery_q <= battery_d;
                    if (cnt_q == C_RST_LAST) begin
                        state_q     <= S_STAGE;
                        cnt_q       <= '0;
                        comp_rst_q  <= 3'b000;
                        en_q[SOLAR] <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_STAGE: begin
                    battery_q <= battery_d;
                    if (cnt_q == C_AIR_CNT) begin
                        en_q[AIRFLOW] <= 1'b1;
                    end
                    if (cnt_q == C_THR_CNT) begin
                        en_q[THRUSTERS] <= 1'b1;
                    end
                    if (cnt_q == C_STAGE_LAST) begin
                        state_q <= S_RUN;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RUN: begin
                    grant_q   <= grant_d;
                    battery_q <= battery_d;
                    rr_ptr_q  <= rr_ptr_d;
                    if (battery_q < BATT_W'(LOW_MARK)) begin
                        state_q         <= S_SHED;
                        en_q[THRUSTERS] <= 1'b0;
                        brownout_q      <= 1'b1;
                    end
                end
                S_SHED: begin
                    grant_q   <= grant_d;
                    battery_q <= battery_d;
                    rr_ptr_q  <= rr_ptr_d;
                    if (battery_q >= BATT_W'(HIGH_MARK)) begin
                        state_q         <= S_RUN;
                        en_q[THRUSTERS] <= 1'b1;
                        brownout_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_OFF;
                end
            endcase
        end
    end

    assign en_o       = en_q;
    assign comp_rst_o = comp_rst_q;
    assign grant_o    = grant_q;
    assign battery_o  = battery_q;
    assign brownout_o = brownout_q;

endmodule

`default_nettype wire

// File: tb/tb_power_sequencer.sv
// ============================================================================
// Module      : tb_power_sequencer
// Description : Scoreboard bench for power_sequencer against a timeline model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_power_sequencer;

    localparam int BATT_CAP   = 1000;
    localparam int BATT_INIT  = 500;
    localparam int LOW_MARK   = 100;
    localparam int HIGH_MARK  = 300;
    localparam int RST_CYCLES = 4;
    localparam int STAGGER    = 8;
    localparam int RUN_AT     = RST_CYCLES + 3 * STAGGER;

    typedef struct packed {
        logic [2:0] en;
        logic [2:0] crst;
        logic [2:0] grant;
        logic [9:0] batt;
        logic       brown;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] req;
    logic [7:0] demand0, demand1, demand2, gen;
    logic       alert;
    logic [2:0] en, comp_rst, grant;
    logic [9:0] battery;
    logic       brownout;

    int   n_checks;
    int   n_errors;
    exp_t exp_q[$];

    int   m_on, m_t, m_shed, m_batt, m_rr;
    logic [2:0] m_grant;

    power_sequencer u_dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .req_i      (req),
        .demand0_i  (demand0),
        .demand1_i  (demand1),
        .demand2_i  (demand2),
        .gen_i      (gen),
        .alert_i    (alert),
        .en_o       (en),
        .comp_rst_o (comp_rst),
        .grant_o    (grant),
        .battery_o  (battery),
        .brownout_o (brownout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Model: time since start plus a shed flag; arbitration walks an explicit visit list.
    task automatic model_step();
        int budget, spent, remain, old, last;
        int dem[3];
        int order[$];
        exp_t e;
        m_grant = 3'b000;
        if (!rst) begin
            m_on = 0; m_shed = 0; m_batt = BATT_INIT; m_rr = 0; m_t = 0;
        end else if (m_on == 0) begin
            if (start) begin
                m_on = 1; m_t = 0;
            end
        end else if (!start) begin
            m_on = 0; m_shed = 0;
        end else begin
            budget = m_batt + int'(gen);
            if (m_t >= RUN_AT) begin
                dem[0] = int'(demand0); dem[1] = int'(demand1); dem[2] = int'(demand2);
                if (alert || m_shed != 0) order.push_back(0);
                for (int k = 0; k < 3; k++) begin
                    if (!((alert || m_shed != 0) && ((m_rr + k) % 3) == 0))
                        order.push_back((m_rr + k) % 3);
                end
                remain = budget; spent = 0; last = -1;
                foreach (order[j]) begin
                    if (req[order[j]] && !(m_shed != 0 && order[j] == 1) && dem[order[j]] <= remain) begin
                        m_grant[order[j]] = 1'b1;
                        remain -= dem[order[j]];
                        spent  += dem[order[j]];
                        last = order[j];
                    end
                end
                if (last >= 0) m_rr = (last + 1) % 3;
                old = m_batt;
                m_batt = (budget - spent > BATT_CAP) ? BATT_CAP : budget - spent;
                if (m_shed == 0 && old < LOW_MARK) m_shed = 1;
                else if (m_shed != 0 && old >= HIGH_MARK) m_shed = 0;
            end else begin
                m_batt = (budget > BATT_CAP) ? BATT_CAP : budget;
            end
            if (m_t < 10000) m_t++;
        end
        e.crst  = (m_on != 0 && m_t >= RST_CYCLES) ? 3'b000 : 3'b111;
        e.en[2] = (m_on != 0 && m_t >= RST_CYCLES);
        e.en[0] = (m_on != 0 && m_t >= RST_CYCLES + STAGGER);
        e.en[1] = (m_on != 0 && m_t >= RST_CYCLES + 2 * STAGGER && m_shed == 0);
        e.grant = m_grant;
        e.batt  = 10'(m_batt);
        e.brown = (m_shed != 0);
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic r, input logic s, input logic [2:0] rq,
                         input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                         input logic [7:0] g, input logic al);
        @(negedge clk);
        rst = r; start = s; req = rq;
        demand0 = d0; demand1 = d1; demand2 = d2; gen = g; alert = al;
        model_step();
    endtask

    function automatic logic [7:0] rand_dem();
        if ($urandom_range(0, 7) == 0) return 8'd0;
        return 8'($urandom_range(0, 150));
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("en",       32'(en),       32'(e.en));
                chk("comp_rst", 32'(comp_rst), 32'(e.crst));
                chk("grant",    32'(grant),    32'(e.grant));
                chk("battery",  32'(battery),  32'(e.batt));
                chk("brownout", 32'(brownout), 32'(e.brown));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_errors = 0;
        m_on = 0; m_t = 0; m_shed = 0; m_batt = BATT_INIT; m_rr = 0;
        rst = 1'b0; start = 1'b0; req = 3'b000; alert = 1'b0;
        demand0 = 8'd0; demand1 = 8'd0; demand2 = 8'd0; gen = 8'd0;

        drive(0, 0, 3'b000, 0, 0, 0, 0, 0);
        drive(0, 1, 3'b111, 0, 0, 0, 0, 0);

        // Start-up with gen=0 so the battery stays at its initial value.
        drive(1, 1, 3'b000, 0, 0, 0, 0, 0);
        for (int i = 0; i < RUN_AT; i++)
            drive(1, 1, 3'($urandom), rand_dem(), rand_dem(), rand_dem(), 0, 1'($urandom));

        drive(1, 1, 3'b111, 250, 255, 150, 0, 0);   // grant 101, battery 100
        drive(1, 1, 3'b001, 0, 0, 0, 250, 0);       // battery 350, rr -> 1
        drive(1, 1, 3'b011, 255, 200, 0, 0, 1);     // airflow first, battery 95
        drive(1, 1, 3'b000, 0, 0, 0, 0, 0);         // enters shed
        for (int i = 0; i < 5; i++)
            drive(1, 1, 3'b010, 0, 0, 0, 50, 0);    // thruster request ignored
        drive(1, 1, 3'b000, 0, 0, 0, 255, 0);       // back to run
        drive(1, 1, 3'b000, 0, 0, 0, 255, 0);
        drive(1, 1, 3'b000, 0, 0, 0, 125, 0);
        drive(1, 1, 3'b000, 0, 0, 0, 100, 0);       // saturates at cap
        drive(1, 0, 3'b111, 10, 10, 10, 100, 0);    // shutdown keeps battery
        drive(1, 0, 3'b111, 10, 10, 10, 100, 0);

        for (int i = 0; i < 800; i++) begin
            drive(($urandom_range(0, 399) != 0),
                  ($urandom_range(0, 59) != 0),
                  3'($urandom), rand_dem(), rand_dem(), rand_dem(),
                  8'($urandom_range(0, 120)), ($urandom_range(0, 3) == 0));
        end

        repeat (3) @(negedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
